// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Responder end of the CPU memory bus. Every rising edge while idle is an
//   access. The access is served from internal synchronous RAM, from a small
//   memory-mapped I/O page (LED, cycle counter, interval timer, error
//   counter), or answered with 0xDEADBEEF when the address is unmapped.
//   I/O-page accesses can be given wait states, during which the CPU is held
//   with stall. The interval timer drives IRQ/IRQn.
//
// Ports
//   clk      in   1   rising-edge clock for all state
//   reset    in   1   synchronous reset, active high
//   address  in  16   word address from CPU
//   data     in  32   write data from CPU
//   wren     in   1   1 = write access, 0 = read access
//   q        out 32   read data to CPU (driven only from flops)
//   stall    out  1   CPU hold request (combinational)
//   IRQ      out  1   one-cycle timer interrupt pulse (registered)
//   IRQn     out  8   TIMER_IRQN while IRQ=1, else 0
//   led      out  8   LED register contents
//
// I/O page at word addresses 0xF000..0xF004:
//   +0 LED (rw, 8 bit)  +1 CYCLES (ro)  +2 RELOAD (rw)  +3 TCOUNT (ro)
//   +4 ERRCNT (ro, any write clears it)
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned RAM_WORDS   = 4096,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  TIMER_IRQN  = 8'h01,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  output logic        stall,
  output logic        IRQ,
  output logic [7:0]  IRQn,
  output logic [7:0]  led
);

  localparam int unsigned AW  = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  // wcnt only ever holds W-1 down to 0
  localparam int unsigned WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [WCW-1:0] WCNT_INIT = WCW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [31:0] BAD_WORD  = 32'hDEADBEEF;

  localparam logic [3:0] OFS_LED    = 4'd0;
  localparam logic [3:0] OFS_CYCLES = 4'd1;
  localparam logic [3:0] OFS_RELOAD = 4'd2;
  localparam logic [3:0] OFS_TCOUNT = 4'd3;
  localparam logic [3:0] OFS_ERRCNT = 4'd4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          state_q;
  logic [WCW-1:0]  wcnt_q;
  logic [7:0]      led_q;
  logic [31:0]     cycles_q;
  logic [31:0]     reload_q;
  logic [31:0]     tcount_q;
  logic [15:0]     errcnt_q;
  logic            irq_q;

  // q is a mux between two flops: the RAM read register (kept free of reset
  // so it maps onto the block-RAM output register) and a register for
  // everything else. q_sel_ram_q picks which one holds the latest answer.
  logic            q_sel_ram_q;
  logic [31:0]     q_other_q;
  logic [31:0]     ram_rdata_q;

  logic [31:0]     ram_mem [RAM_WORDS];

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [3:0]    offset;
  logic          is_ram;
  logic          is_io;
  logic          acc_idle;
  logic          ram_en;
  logic          unmapped_acc;
  logic          io_fire;
  logic          reload_wr;
  logic          errcnt_clr;
  logic [AW-1:0] ram_addr;
  logic [31:0]   io_rdata;

  assign offset   = address[3:0];
  assign is_ram   = (32'(address) < RAM_WORDS);
  assign is_io    = (address[15:4] == 12'hF00) && (offset <= OFS_ERRCNT);
  assign ram_addr = address[AW-1:0];

  assign acc_idle     = !reset && (state_q == S_IDLE);
  assign ram_en       = acc_idle && is_ram;
  assign unmapped_acc = acc_idle && !is_ram && !is_io;

  // Edge at which an I/O access takes effect: the idle edge itself with no
  // wait states, otherwise the last edge of the WAIT state.
  assign io_fire = !reset && (ZERO_WAIT ? (state_q == S_IDLE && is_io)
                                        : (state_q == S_WAIT && wcnt_q == '0));

  assign reload_wr  = io_fire && wren && (offset == OFS_RELOAD);
  assign errcnt_clr = io_fire && wren && (offset == OFS_ERRCNT);

  always_comb begin
    io_rdata = BAD_WORD;
    case (offset)
      OFS_LED:    io_rdata = {24'h0, led_q};
      OFS_CYCLES: io_rdata = cycles_q;
      OFS_RELOAD: io_rdata = reload_q;
      OFS_TCOUNT: io_rdata = tcount_q;
      OFS_ERRCNT: io_rdata = {16'h0, errcnt_q};
      default:    io_rdata = BAD_WORD;
    endcase
  end

  // Held high from the idle cycle that presents an I/O address until the
  // wait counter has run out, i.e. exactly WAIT_STATES cycles.
  always_comb begin
    stall = 1'b0;
    if (!reset && !ZERO_WAIT) begin
      if (state_q == S_IDLE) stall = is_io;
      else                   stall = (wcnt_q != '0);
    end
  end

  // ---------------------------------------------------------------------
  // RAM: write-first is not wanted, the read returns the old word.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (wren) ram_mem[ram_addr] <= data;
      ram_rdata_q <= ram_mem[ram_addr];
    end
  end

  // ---------------------------------------------------------------------
  // Bus FSM, I/O registers, counters and timer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      q_sel_ram_q <= 1'b0;
      q_other_q   <= 32'h0;
      led_q       <= 8'h0;
      cycles_q    <= 32'h0;
      reload_q    <= 32'h0;
      tcount_q    <= 32'h0;
      errcnt_q    <= 16'h0;
      irq_q       <= 1'b0;
    end else begin
      cycles_q <= cycles_q + 32'd1;

      case (state_q)
        S_IDLE: begin
          if (is_ram) begin
            q_sel_ram_q <= 1'b1;
          end else if (!is_io) begin
            q_sel_ram_q <= 1'b0;
            q_other_q   <= BAD_WORD;
          end else if (!ZERO_WAIT) begin
            state_q <= S_WAIT;
            wcnt_q  <= WCNT_INIT;
          end
        end
        S_WAIT: begin
          if (wcnt_q != '0) wcnt_q <= wcnt_q - WCW'(1);
          else              state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // I/O completion: answer with the pre-write value, then apply the write.
      // CYCLES and TCOUNT writes fall through and are dropped.
      if (io_fire) begin
        q_sel_ram_q <= 1'b0;
        q_other_q   <= io_rdata;
        if (wren && offset == OFS_LED) led_q <= data[7:0];
      end

      if (errcnt_clr)
        errcnt_q <= 16'h0;
      else if (unmapped_acc && errcnt_q != 16'hFFFF)
        errcnt_q <= errcnt_q + 16'd1;

      // A RELOAD write restarts the timer and suppresses a coincident expiry.
      if (reload_wr) begin
        reload_q <= data;
        tcount_q <= data;
        irq_q    <= 1'b0;
      end else if (reload_q != 32'h0) begin
        if (tcount_q <= 32'd1) begin
          tcount_q <= reload_q;
          irq_q    <= 1'b1;
        end else begin
          tcount_q <= tcount_q - 32'd1;
          irq_q    <= 1'b0;
        end
      end else begin
        irq_q <= 1'b0;
      end
    end
  end

  assign q    = q_sel_ram_q ? ram_rdata_q : q_other_q;
  assign IRQ  = irq_q;
  assign IRQn = irq_q ? TIMER_IRQN : 8'h00;
  assign led  = led_q;

endmodule
